// File: rtl/imm_ext_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : imm_ext_unit
//  Purpose  : Valid/ready immediate extender: sign/zero extend, sign-extend
//             with shift-left-1, and two-beat concatenate with sign extension.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_ext_unit #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IN_W-1:0]  INPUT,
  input  logic [1:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OUT_W-1:0] OUTPUT,
  output logic             BUSY
);

  if (OUT_W < 2*IN_W) begin : g_width_check
    $error("imm_ext_unit: OUT_W must be at least 2*IN_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LO = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [OUT_W-1:0]  result_q, result_d;
  logic [IN_W-1:0]   hi_q, hi_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic [OUT_W-1:0]  sext_in;
  logic [OUT_W-1:0]  zext_in;
  logic [OUT_W-1:0]  sext_cat;
  logic [OUT_W-1:0]  single_res;

  // Held in reset means no beat can be taken, including on the release edge.
  assign IN_READY = RESET_N && ((state_q != ST_FULL) || OUT_READY);
  assign accept   = IN_VALID && IN_READY;

  assign sext_in  = OUT_W'($signed(INPUT));
  assign zext_in  = OUT_W'(INPUT);
  assign sext_cat = OUT_W'($signed({hi_q, INPUT}));

  always_comb begin
    single_res = sext_in;
    case (MODE)
      2'b01:   single_res = zext_in;
      2'b10:   single_res = {sext_in[OUT_W-2:0], 1'b0};
      default: single_res = sext_in;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    case (state_q)
      ST_WAIT_LO: begin
        // MODE on the low beat is deliberately ignored.
        if (accept) begin
          result_d = sext_cat;
          hi_d     = '0;
          state_d  = ST_FULL;
        end
      end
      default: begin
        // IDLE and a draining FULL behave alike: a new beat may start here.
        if (state_q == ST_FULL && OUT_READY) begin
          state_d = ST_IDLE;
        end
        if (accept) begin
          if (MODE == 2'b11) begin
            hi_d    = INPUT;
            state_d = ST_WAIT_LO;
          end else begin
            result_d = single_res;
            state_d  = ST_FULL;
          end
        end
      end
    endcase
    out_valid_d = (state_d == ST_FULL);
    busy_d      = (state_d == ST_WAIT_LO);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      hi_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign OUTPUT    = result_q;
  assign OUT_VALID = out_valid_q;
  assign BUSY      = busy_q;

endmodule
`default_nettype wire
